uart_tx_serializer: RTL and testbench

- UART transmit serializer: accepts a parallel character over a valid/ready handshake and shifts it out LSB-first on a serial line as start, data, optional parity and stop bits.
- Sits directly upstream of the serial parity generator. It drives that block's clear, sample-strobe and data inputs, and consumes its parity output to form the parity bit.
- Bit timing comes from an external 16x baud-rate enable pulse.

---
 rtl/uart_tx_serializer.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 5-8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Optional macro UART_TX_BREAK_EN adds a tx_break input that forces the line low.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [1:0]        num_bits,
    input  logic              stop2,
    input  logic              par_en,
    input  logic              par_even,
    output logic              par_srst,
    output logic              par_sd,
    output logic              par_d,
    input  logic              par_q,
`ifdef UART_TX_BREAK_EN
    input  logic              tx_break,
`endif
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_r;
    logic [TICK_W-1:0] tick_r;
    logic [IDX_W-1:0]  idx_r;
    logic              stop_cnt_r;
    logic [DATA_W-1:0] shadow_r;
    logic [1:0]        nb_r;
    logic              stop2_r;
    logic              par_en_r;
    logic              par_even_r;
    logic              tx_r;
    logic              done_r;
    logic              par_srst_r;
    logic              par_sd_r;
    logic              par_d_r;

    logic              bit_end_s;
    logic              last_data_s;
    logic              par_bit_s;
    logic [IDX_W-1:0]  last_idx_s;
    logic [IDX_W-1:0]  next_idx_s;

    // Bit-boundary detection and next data index.
    always_comb begin
        bit_end_s   = br_en && (tick_r == TICK_W'(OVERSAMPLE - 1));
        last_idx_s  = IDX_W'(nb_r) + IDX_W'(4);
        next_idx_s  = idx_r + IDX_W'(1);
        last_data_s = (idx_r == last_idx_s);
        par_bit_s   = par_even_r ? par_q : ~par_q;
    end

    // Frame sequencer: state, bit timing, line value and parity-generator strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            tick_r     <= {TICK_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            stop_cnt_r <= 1'b0;
            shadow_r   <= {DATA_W{1'b0}};
            nb_r       <= 2'd0;
            stop2_r    <= 1'b0;
            par_en_r   <= 1'b0;
            par_even_r <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            par_srst_r <= 1'b0;
            par_sd_r   <= 1'b0;
            par_d_r    <= 1'b0;
        end else begin
            par_srst_r <= 1'b0;
            par_sd_r   <= 1'b0;
            done_r     <= 1'b0;
            if ((state_r != S_IDLE) && br_en) begin
                tick_r <= bit_end_s ? {TICK_W{1'b0}} : tick_r + TICK_W'(1);
            end
            case (state_r)
                S_IDLE: begin
                    if (din_valid) begin
                        shadow_r   <= din;
                        nb_r       <= num_bits;
                        stop2_r    <= stop2;
                        par_en_r   <= par_en;
                        par_even_r <= par_even;
                        par_srst_r <= 1'b1;
                        tx_r       <= 1'b0;
                        tick_r     <= {TICK_W{1'b0}};
                        state_r    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_r  <= S_DATA;
                        idx_r    <= {IDX_W{1'b0}};
                        tx_r     <= shadow_r[0];
                        par_sd_r <= 1'b1;
                        par_d_r  <= shadow_r[0];
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        if (!last_data_s) begin
                            idx_r    <= next_idx_s;
                            tx_r     <= shadow_r[next_idx_s];
                            par_sd_r <= 1'b1;
                            par_d_r  <= shadow_r[next_idx_s];
                        end else if (par_en_r) begin
                            state_r <= S_PARITY;
                            tx_r    <= par_bit_s;
                        end else begin
                            state_r    <= S_STOP;
                            stop_cnt_r <= 1'b0;
                            tx_r       <= 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end_s) begin
                        state_r    <= S_STOP;
                        stop_cnt_r <= 1'b0;
                        tx_r       <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        if (stop2_r && !stop_cnt_r) begin
                            stop_cnt_r <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign din_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign done      = done_r;
    assign par_srst  = par_srst_r;
    assign par_sd    = par_sd_r;
    assign par_d     = par_d_r;

`ifdef UART_TX_BREAK_EN
    // Break overrides the line after the register; sequencing continues underneath.
    assign tx = tx_r & ~tx_break;
`else
    assign tx = tx_r;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed table, reset abort, optional break, random frames.
// The expected line waveform comes from a frame-level model (bit list per character).
module tb_uart_tx_serializer;

    localparam int OS = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          br_en;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [1:0]    num_bits;
    logic          stop2;
    logic          par_en;
    logic          par_even;
    logic          par_srst;
    logic          par_sd;
    logic          par_d;
    logic          par_q;
    logic          tx;
    logic          busy;
    logic          done;
`ifdef UART_TX_BREAK_EN
    logic          tx_break = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int srst_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_en     (br_en),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .num_bits  (num_bits),
        .stop2     (stop2),
        .par_en    (par_en),
        .par_even  (par_even),
        .par_srst  (par_srst),
        .par_sd    (par_sd),
        .par_d     (par_d),
        .par_q     (par_q),
`ifdef UART_TX_BREAK_EN
        .tx_break  (tx_break),
`endif
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    // Stand-in for the downstream serial parity generator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           par_q <= 1'b0;
        else if (par_srst) par_q <= 1'b0;
        else if (par_sd)   par_q <= par_q ^ par_d;
    end

    always @(posedge clk) begin
        if (par_srst === 1'b1) srst_cnt <= srst_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: list of line levels, one per bit, with kind 0=start 1=data 2=parity 3=stop.
    logic m_bit  [0:15];
    int   m_kind [0:15];
    int   m_len;

    task automatic model_frame(input logic [7:0] data, input logic [1:0] nb,
                               input logic s2, input logic pe, input logic pev);
        int   n;
        logic p;
        n = 5 + int'(nb);
        m_len = 0;
        m_bit[m_len] = 1'b0; m_kind[m_len] = 0; m_len++;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            m_bit[m_len] = data[i]; m_kind[m_len] = 1; m_len++;
            p = p ^ data[i];
        end
        if (pe) begin
            m_bit[m_len] = pev ? p : ~p; m_kind[m_len] = 2; m_len++;
        end
        m_bit[m_len] = 1'b1; m_kind[m_len] = 3; m_len++;
        if (s2) begin
            m_bit[m_len] = 1'b1; m_kind[m_len] = 3; m_len++;
        end
    endtask

    // Sends one character and checks every clk of the frame; called just after a negedge with DUT idle.
    task automatic frame(input logic [7:0] data, input logic [1:0] nb, input logic s2,
                         input logic pe, input logic pev, input int gap, input bit hold,
                         input int abort_at, input int brk_at,
                         output int done_at, output logic par_seen);
        int   bad_tx, bad_sd, bad_oth, cyc;
        logic exp_tx;
        model_frame(data, nb, s2, pe, pev);
        done_at  = -1;
        par_seen = 1'bx;
        check("ready_before_accept", 32'(din_ready), 32'd1);
        din = data; num_bits = nb; stop2 = s2; par_en = pe; par_even = pev;
        din_valid = 1'b1;
        br_en = (gap == 1);
        @(posedge clk);
        @(negedge clk);
        din_valid = hold;
        din = 8'($urandom); num_bits = 2'($urandom); stop2 = 1'($urandom);
        par_en = 1'($urandom); par_even = 1'($urandom);
        for (int b = 0; b < m_len; b++) begin
            bad_tx = 0; bad_sd = 0; bad_oth = 0;
            for (int c = 0; c < OS * gap; c++) begin
                cyc = b * OS * gap + c;
                if (cyc == abort_at) begin
                    #2 rst = 1'b1;
                    #1 check("abort_async", 32'({tx, busy, din_ready, done}), 32'b1010);
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    bad_oth = 0;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        #1;
                        if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad_oth++;
                    end
                    check("abort_quiet", 32'(bad_oth), 32'd0);
                    done_at = -2;
                    return;
                end
                exp_tx = m_bit[b];
`ifdef UART_TX_BREAK_EN
                tx_break = (brk_at >= 0) && (cyc >= brk_at) && (cyc < brk_at + 3);
                if (tx_break) exp_tx = 1'b0;
`endif
                #1;
                if (tx !== exp_tx) bad_tx++;
                if (par_sd !== ((m_kind[b] == 1) && (c == 0))) bad_sd++;
                if (par_sd === 1'b1 && par_d !== m_bit[b]) bad_sd++;
                if (par_srst !== (cyc == 0)) bad_oth++;
                if (busy !== 1'b1 || din_ready !== 1'b0) bad_oth++;
                if (done === 1'b1 && done_at < 0) done_at = cyc;
                if (m_kind[b] == 2 && c == 0) par_seen = tx;
                br_en = (gap == 1) || ((c % gap) == gap - 1);
                @(posedge clk);
                @(negedge clk);
            end
            check($sformatf("tx_bit%0d", b), 32'(bad_tx), 32'd0);
            check($sformatf("par_strobe_bit%0d", b), 32'(bad_sd), 32'd0);
            check($sformatf("srst_busy_bit%0d", b), 32'(bad_oth), 32'd0);
        end
`ifdef UART_TX_BREAK_EN
        tx_break = 1'b0;
`endif
        #1;
        if (done === 1'b1 && done_at < 0) done_at = m_len * OS * gap;
        check("end_done_ready_busy_tx_srst", 32'({done, din_ready, busy, tx, par_srst}), 32'b11010);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] nb;
        logic       s2;
        logic       pe;
        logic       pev;
        int         gap;
        bit         hold;
        int         exp_bits;
        logic       exp_par;
    } vec_t;

    vec_t vecs [0:5];

    task automatic idle_after();
        din_valid = 1'b0;
        br_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 check("done_single_pulse", 32'({done, din_ready, tx}), 32'b011);
    endtask

    initial begin : main
        int   dat;
        logic ps;
        int   s0;
        logic [7:0] rd;
        logic [1:0] rnb;
        logic rs2, rpe, rpev;
        int   rgap;

        vecs[0] = '{8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 10, 1'b0};
        vecs[1] = '{8'h83, 2'd2, 1'b0, 1'b1, 1'b1, 1, 1'b0, 10, 1'b0};
        vecs[2] = '{8'h1F, 2'd0, 1'b1, 1'b1, 1'b0, 1, 1'b0,  9, 1'b0};
        vecs[3] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b1, 10, 1'b0};
        vecs[4] = '{8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0, 10, 1'b0};
        vecs[5] = '{8'hC6, 2'd3, 1'b1, 1'b1, 1'b1, 7, 1'b0, 12, 1'b0};

        rst = 1'b1; br_en = 1'b0; din = 8'h00; din_valid = 1'b0;
        num_bits = 2'd0; stop2 = 1'b0; par_en = 1'b0; par_even = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_values", 32'({tx, din_ready, busy, done, par_srst, par_sd, par_d}), 32'b1100000);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            s0 = srst_cnt;
            frame(vecs[v].data, vecs[v].nb, vecs[v].s2, vecs[v].pe, vecs[v].pev,
                  vecs[v].gap, vecs[v].hold, -1, -1, dat, ps);
            check($sformatf("done_time_v%0d", v), 32'(dat), 32'(vecs[v].exp_bits * OS * vecs[v].gap));
            if (vecs[v].pe) check($sformatf("parity_v%0d", v), 32'(ps), 32'(vecs[v].exp_par));
            if (v == 4) check("srst_back_to_back", 32'(srst_cnt - s0 + 1), 32'd2);
            if (!vecs[v].hold) idle_after();
        end

        // 6O1 on a 1-in-3 baud enable: 6-bit 0x2D has four ones, odd parity sends 1.
        frame(8'hED, 2'd1, 1'b0, 1'b1, 1'b0, 3, 1'b0, -1, -1, dat, ps);
        check("done_time_6o1", 32'(dat), 32'(9 * OS * 3));
        check("parity_6o1", 32'(ps), 32'd1);
        idle_after();

        // Reset in the middle of the data bits, then a clean frame.
        frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0, OS + 40, -1, dat, ps);
        check("abort_no_done", 32'(dat), 32'hFFFF_FFFE);
        @(negedge clk);
        frame(8'h96, 2'd3, 1'b0, 1'b1, 1'b1, 1, 1'b0, -1, -1, dat, ps);
        check("after_abort_done_time", 32'(dat), 32'(11 * OS));
        check("after_abort_parity", 32'(ps), 32'd0);
        idle_after();

`ifdef UART_TX_BREAK_EN
        frame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1, 1'b0, -1, 20, dat, ps);
        check("break_done_time", 32'(dat), 32'(10 * OS));
        idle_after();
`endif

        for (int r = 0; r < 12; r++) begin
            rd   = 8'($urandom);
            rnb  = 2'($urandom_range(0, 3));
            rs2  = 1'($urandom);
            rpe  = 1'($urandom);
            rpev = 1'($urandom);
            rgap = $urandom_range(1, 3);
            frame(rd, rnb, rs2, rpe, rpev, rgap, 1'b0, -1, -1, dat, ps);
            check($sformatf("rand%0d_done_time", r), 32'(dat), 32'(m_len * OS * rgap));
            idle_after();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
